// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE    = 2'd0,
      STATE_RUNNING = 2'd1,
      STATE_EXPIRED = 2'd2
   } state_e;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a controller (master) and the countdown timer (slave).
interface countdown_timer_if #(
   parameter int WIDTH = 4
);

   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             auto_reload;
   logic             stop;
   logic             enb;
   logic [WIDTH-1:0] count;
   logic             borrowout;
   logic             busy;
   logic             expired;

   modport master (
      output load, load_value, auto_reload, stop, enb,
      input  count, borrowout, busy, expired
   );

   modport slave (
      input  load, load_value, auto_reload, stop, enb,
      output count, borrowout, busy, expired
   );

endinterface : countdown_timer_if

// File: rtl/countdown_timer_tick_divider.sv
// Prescaler: one tick every PRESCALE enabled cycles. With PRESCALE=1 the
// counter register never leaves zero, so tick simply follows enb.
module tick_divider #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic enb,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q;

   assign tick = enb && (presc_q == LAST);

   // Advance on each enabled cycle, wrap on tick, clear when the run restarts or ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else if (clr) begin
         presc_q <= '0;
      end else if (enb) begin
         presc_q <= tick ? '0 : presc_q + PW'(1);
      end
   end

endmodule : tick_divider

// File: rtl/countdown_timer.sv
// Loadable down-counter with a single-cycle borrow pulse on the terminal tick,
// running either one-shot (sticky expired) or periodic (self-reload).
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   countdown_timer_if.slave tif
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             running;
   logic             tick;
   logic             borrow;

   assign running = (state_q == STATE_RUNNING);

   // The prescaler only sees enables while running and restarts on load/stop/idle.
   tick_divider #(
      .PRESCALE (PRESCALE)
   ) u_tick_divider (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tif.load || tif.stop || !running),
      .enb   (tif.enb && running),
      .tick  (tick)
   );

   // Register the FSM state, the live count and the reload value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= STATE_IDLE;
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   // Next state and borrow: load beats stop, stop beats a pending tick.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      borrow   = 1'b0;
      if (tif.load) begin
         state_d  = STATE_RUNNING;
         count_d  = tif.load_value;
         reload_d = tif.load_value;
      end else if (tif.stop) begin
         state_d = STATE_IDLE;
      end else if (running && tick) begin
         if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            borrow = 1'b1;
            if (tif.auto_reload) begin
               count_d = reload_q;
            end else begin
               state_d = STATE_EXPIRED;
            end
         end
      end
   end

   assign tif.count     = count_q;
   assign tif.borrowout = borrow;
   assign tif.busy      = running;
   assign tif.expired   = (state_q == STATE_EXPIRED);

endmodule : countdown_timer
